// File: rtl/trig_series.sv
// Sequential Taylor-series evaluator for cos(x)/sin(x), x in [0,2).
// One shared multiplier; each series term costs three cycles (MX, MC, ACC).
module trig_series #(
  parameter int XW     = 10,
  parameter int FW     = 8,
  parameter int GW     = 4,
  parameter int NTERMS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [XW-1:0] x,
  output logic [1:0]    intpart,
  output logic [FW-1:0] fracpart,
  output logic          busy,
  output logic          done
);

  localparam int IW = FW + GW;
  localparam int TW = IW + 4;
  localparam int AW = IW + 5;
  localparam int XF = XW - 1;
  localparam logic [TW-1:0] ONE = TW'(1) << IW;

  typedef enum logic [2:0] {IDLE, SQR, MX, MC, ACC, FIN} state_t;

  state_t                state_reg, state_next;
  logic [2:0]            k_reg, k_next;
  logic                  mode_reg, mode_next;
  logic [TW-1:0]         xv_reg, xv_next;
  logic [TW-1:0]         x2_reg, x2_next;
  logic [TW-1:0]         term_reg, term_next;
  logic signed [AW-1:0]  acc_reg, acc_next;
  logic [FW+1:0]         res_reg, res_next;
  logic                  done_reg, done_next;

  logic [TW-1:0]   x_iw;
  logic [TW-1:0]   mul_a, mul_b, prod_q, coef;
  logic [2*TW-1:0] prod;
  logic [2:0]      kidx;
  logic [TW-1:0]   cos_tab [8];
  logic [TW-1:0]   sin_tab [8];

  // Re-align the operand from XW-1 to IW fraction bits.
  generate
    if (IW >= XF) begin : g_xup
      assign x_iw = TW'(x) << (IW - XF);
    end else begin : g_xdn
      assign x_iw = TW'(x >> (XF - IW));
    end
  endgenerate

  // Per-term ratio constants: entry gi serves series index k = gi+1.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_tab
      localparam int K = gi + 1;
      assign cos_tab[gi] = TW'((1 << IW) / ((2*K - 1) * (2*K)));
      assign sin_tab[gi] = TW'((1 << IW) / ((2*K) * (2*K + 1)));
    end
  endgenerate

  assign kidx   = k_reg - 3'd1;
  assign coef   = mode_reg ? sin_tab[kidx] : cos_tab[kidx];
  assign prod   = mul_a * mul_b;
  assign prod_q = TW'(prod >> IW);

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    mode_next  = mode_reg;
    xv_next    = xv_reg;
    x2_next    = x2_reg;
    term_next  = term_reg;
    acc_next   = acc_reg;
    res_next   = res_reg;
    done_next  = 1'b0;
    mul_a      = term_reg;
    mul_b      = x2_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next  = mode;
          xv_next    = x_iw;
          k_next     = 3'd1;
          term_next  = mode ? x_iw : ONE;
          acc_next   = AW'(mode ? x_iw : ONE);
          state_next = SQR;
        end
      end
      SQR: begin
        mul_a      = xv_reg;
        mul_b      = xv_reg;
        x2_next    = prod_q;
        state_next = MX;
      end
      MX: begin
        term_next  = prod_q;
        state_next = MC;
      end
      MC: begin
        mul_b      = coef;
        term_next  = prod_q;
        state_next = ACC;
      end
      ACC: begin
        if (k_reg[0]) acc_next = acc_reg - $signed(AW'(term_reg));
        else          acc_next = acc_reg + $signed(AW'(term_reg));
        if (k_reg == 3'(NTERMS - 1)) begin
          state_next = FIN;
        end else begin
          k_next     = k_reg + 3'd1;
          state_next = MX;
        end
      end
      FIN: begin
        // Arithmetic shift drops the guard bits with floor rounding.
        res_next   = (FW+2)'(acc_reg >>> GW);
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      mode_reg  <= 1'b0;
      xv_reg    <= '0;
      x2_reg    <= '0;
      term_reg  <= '0;
      acc_reg   <= '0;
      res_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      mode_reg  <= mode_next;
      xv_reg    <= xv_next;
      x2_reg    <= x2_next;
      term_reg  <= term_next;
      acc_reg   <= acc_next;
      res_reg   <= res_next;
      done_reg  <= done_next;
    end
  end

  assign intpart  = res_reg[FW+1:FW];
  assign fracpart = res_reg[FW-1:0];
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;

endmodule

// File: doc/trig_series.md
TRIG_SERIES -- requirements
Module: trig_series

Interface
REQ-001 Parameter XW, default 10, x input width: unsigned fixed point, 1 integer bit and XW-1 fraction bits, range [0, 2).
REQ-002 Parameter FW, default 8, result fraction width.
REQ-003 Parameter GW, default 4, internal guard bits; internal fraction width IW = FW+GW.
REQ-004 Parameter NTERMS, default 4, number of series terms including term 0; legal range 2..8.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request; sampled only in IDLE.
REQ-008 mode  input  1  0 = cosine, 1 = sine; latched with x on accept.
REQ-009 x  input  XW  operand, latched on accept.
REQ-010 intpart  output  2  two's-complement integer part of result.
REQ-011 fracpart  output  FW  fraction part of result.
REQ-012 busy  output  1  high while a computation is in progress.
REQ-013 done  output  1  one-cycle pulse when the result is updated.

Function
REQ-014 FSM states: IDLE, SQR, MX, MC, ACC, FIN; IDLE with start=1 accepts: latch x and mode, set k=1; cos: term=1.0, acc=1.0; sin: term=x, acc=x; go to SQR.
REQ-015 SQR: x2 = floor(x*x) at IW fraction bits; go to MX.
REQ-016 MX: term = floor(term*x2) at IW fraction bits; go to MC.
REQ-017 MC: term = floor(term*c_k) at IW fraction bits; cos c_k = floor(2^IW/((2k-1)(2k))), sin c_k = floor(2^IW/((2k)(2k+1))), from a constant table; go to ACC.
REQ-018 ACC: acc = acc - term for odd k, acc + term for even k; if k == NTERMS-1 go to FIN, else k = k+1 and go to MX.
REQ-019 term is an unsigned magnitude; term and acc are sized (at least IW+3 integer-inclusive bits, acc signed) so no overflow occurs for any x < 2 and NTERMS <= 8.
REQ-020 FIN: {intpart, fracpart} = floor(acc / 2^GW) as a (FW+2)-bit two's-complement value; done=1 for this cycle only; go to IDLE.
REQ-021 Latency: done asserts 3*(NTERMS-1)+2 cycles after the accepting edge (11 cycles at NTERMS=4); a new start is accepted the cycle after done.
REQ-022 busy is high from the cycle after accept through the FIN cycle inclusive; low in IDLE.
REQ-023 start while busy is ignored with no effect on the running computation; x/mode changes during busy are ignored.
REQ-024 intpart/fracpart hold their last value until the next FIN; they do not change during a computation.
REQ-025 start held high continuously starts back-to-back computations, each using x/mode sampled in IDLE.

Reset
REQ-026 rst=0 immediately forces IDLE, intpart=0, fracpart=0, busy=0, done=0, clears internal registers, including mid-computation; no done pulse for an aborted operation.
REQ-027 First accept is possible on the first rising edge with rst=1 and start=1.

Verification (defaults XW=10, FW=8, GW=4, NTERMS=4)
REQ-028 cos, x=10'b0000000000 -> done 11 cycles after accept, intpart=2'b01, fracpart=8'h00.
REQ-029 cos, x=10'b0110000000 (0.75) -> intpart=2'b00, fracpart=8'hBB; cos, x=10'b1000000000 (1.0) -> intpart=2'b00, fracpart=8'h8A.
REQ-030 cos, x=10'b1110000000 (1.75) -> intpart=2'b11, fracpart=8'hD1 (-47/256).
REQ-031 sin, x=10'b1000000000 (1.0) -> intpart=2'b00, fracpart=8'hD7.
REQ-032 start pulsed again at cycle 5 of a run with different x -> ignored, first result unchanged; rst=0 asserted at cycle 6 -> all outputs 0 at once, no done; next start after release gives correct result.
REQ-033 start held high for 3 runs -> three done pulses spaced 12 cycles apart, busy low exactly one cycle between runs.
